// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch: instruction-fetch front end for the multi-cycle MIPS core.
// Holds the architectural PC (word address, byte bits 31:2). On fetch_start it
// runs one request/acknowledge read to instruction memory and latches the
// returned word into the instruction register.
//
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch after
// TIMEOUT_CYCLES WAIT cycles without acknowledge (fetch_err pulses).
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   fetch_start   controller pulse, start a fetch from the current PC
//   pc_wr, npc    load PC from the next-PC word address
//   pc            current PC word address
//   imem_req      read request, held until acknowledge
//   imem_addr     word address of the request
//   imem_ack      memory acknowledge, imem_rdata valid in the same cycle
//   imem_rdata    instruction word
//   ir, ir_pc     instruction register and the address it came from
//   ir_valid      one-cycle pulse, ir updated
//   busy          fetch outstanding
//   fetch_err     one-cycle pulse, fetch aborted by timeout
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [29:0] RESET_PC       = 30'h0000_0C00,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic        pc_wr,
    input  logic [29:0] npc,
    output logic [29:0] pc,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [29:0] ir_pc,
    output logic        ir_valid,
    output logic        busy,
    output logic        fetch_err
);

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;

    // Reject an out-of-range timeout at elaboration.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("instr_fetch: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] ir_pc_q, ir_pc_d;
    logic [AW-1:0] pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic          ir_valid_q, ir_valid_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          leave_wait;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        ir_pc_d    = ir_pc_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        req_d      = req_q;
        busy_d     = busy_q;
        ir_valid_d = 1'b0;
        ir_d       = ir_q;
        leave_wait = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (pc_wr) begin
                    pc_d = npc;
                end
                if (fetch_start) begin
                    // A simultaneous pc_wr redirects this very fetch.
                    addr_d  = pc_wr ? npc : pc_q;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            S_WAIT: begin
                // PC is frozen while the request is out; keep the newest npc.
                if (pc_wr) begin
                    pend_d     = npc;
                    pend_vld_d = 1'b1;
                end
                if (imem_ack) begin
                    ir_d       = imem_rdata;
                    ir_pc_d    = addr_q;
                    ir_valid_d = 1'b1;
                    leave_wait = 1'b1;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    err_d      = 1'b1;
                    leave_wait = 1'b1;
                end
                else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
                if (leave_wait) begin
                    req_d      = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                    pend_vld_d = 1'b0;
                    if (pc_wr) begin
                        pc_d = npc;
                    end else if (pend_vld_q) begin
                        pc_d = pend_q;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset drops any transaction immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            ir_pc_q    <= RESET_PC;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            ir_valid_q <= 1'b0;
            ir_q       <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            ir_pc_q    <= ir_pc_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            ir_valid_q <= ir_valid_d;
            ir_q       <= ir_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Timeout counter and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign pc        = pc_q;
    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign busy      = busy_q;

endmodule
